// File: rtl/game_pkg.sv
// Shared game constants, ramp FSM encoding and the speed-target helper used by
// the level controller and other game blocks.
package game_pkg;

    localparam int SCORE_W_DEF      = 12;
    localparam int LEVEL_W_DEF      = 3;
    localparam int NUM_LEVELS_DEF   = 6;
    localparam int STEP_DEF         = 7;
    localparam int SPEED_BASE_DEF   = 2;
    localparam int RAMP_TICKS_DEF   = 4;
    localparam int BANNER_TICKS_DEF = 60;

    typedef enum logic {
        STEADY = 1'b0,
        RAMP   = 1'b1
    } ramp_state_e;

    // Speed the game should settle at for a given level, clipped to the output range.
    function automatic int sat_target(int base, int lvl, int max_speed);
        int t;
        t = base + lvl - 1;
        return (t > max_speed) ? max_speed : t;
    endfunction

endpackage

// File: rtl/level_controller_if.sv
// Game-side bundle between the playfield logic and the level controller.
interface level_controller_if import game_pkg::*; #(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int LEVEL_W = LEVEL_W_DEF
);
    logic               restart;
    logic               frame_tick;
    logic [SCORE_W-1:0] score;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] speed;
    logic               level_up;
    logic               banner;
    logic               at_max;

    modport master (
        output restart, frame_tick, score,
        input  level, speed, level_up, banner, at_max
    );

    modport slave (
        input  restart, frame_tick, score,
        output level, speed, level_up, banner, at_max
    );
endinterface

// File: rtl/tick_timer.sv
// Reloadable down-counter that stays busy for LOAD_VALUE ticks after each load.
module tick_timer #(
    parameter int LOAD_VALUE = 60,
    parameter int W          = $clog2(LOAD_VALUE + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         busy
);
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= W'(LOAD_VALUE);
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);
endmodule

// File: rtl/level_controller.sv
// Score-driven level tracker with a frame-paced speed ramp and a level-up banner.
module level_controller import game_pkg::*; #(
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int LEVEL_W      = LEVEL_W_DEF,
    parameter int NUM_LEVELS   = NUM_LEVELS_DEF,
    parameter int STEP         = STEP_DEF,
    parameter int SPEED_BASE   = SPEED_BASE_DEF,
    parameter int RAMP_TICKS   = RAMP_TICKS_DEF,
    parameter int BANNER_TICKS = BANNER_TICKS_DEF
) (
    input logic               clock,
    input logic               reset,
    level_controller_if.slave bus
);
    localparam int TW        = SCORE_W + 1;
    localparam int CNT_W     = $clog2(RAMP_TICKS + 1);
    localparam int SPEED_MAX = (1 << LEVEL_W) - 1;
    localparam int BAN_W     = $clog2(BANNER_TICKS + 1);

    localparam logic [TW-1:0]      STEP_V  = TW'(STEP);
    localparam logic [LEVEL_W-1:0] LV_ONE  = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LV_MAX  = LEVEL_W'(NUM_LEVELS);
    localparam logic [LEVEL_W-1:0] SPD_RST = LEVEL_W'(SPEED_BASE);

    logic [LEVEL_W-1:0] level, level_d, speed, speed_d, target_d;
    logic [TW-1:0]      lo, hi;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
    logic               go_up, go_down, level_up, at_max;
    logic [BAN_W-1:0]   unused_banner_count;
    ramp_state_e        state, state_d;

    // Up and down cannot both hold since lo < hi; the hi test is masked at the top level.
    always_comb begin
        go_up    = (level < LV_MAX) && ({1'b0, bus.score} >= hi);
        go_down  = (level > LV_ONE) && ({1'b0, bus.score} < lo);
        level_d  = level;
        if (go_up)        level_d = level + 1'b1;
        else if (go_down) level_d = level - 1'b1;
        target_d = LEVEL_W'(sat_target(SPEED_BASE, int'(level_d), SPEED_MAX));
    end

    // Target follows the incoming level, so a tick on the level-change edge counts toward the ramp.
    always_comb begin
        state_d = state;
        speed_d = speed;
        cnt_d   = cnt;
        cnt_inc = ((state == STEADY) ? '0 : cnt) + CNT_W'(bus.frame_tick);
        if (target_d < speed) begin
            speed_d = target_d;
            state_d = STEADY;
            cnt_d   = '0;
        end else if (target_d > speed) begin
            if (cnt_inc == CNT_W'(RAMP_TICKS)) begin
                speed_d = speed + 1'b1;
                cnt_d   = '0;
                state_d = (speed_d == target_d) ? STEADY : RAMP;
            end else begin
                cnt_d   = cnt_inc;
                state_d = RAMP;
            end
        end else begin
            state_d = STEADY;
            cnt_d   = '0;
        end
    end

    // NOTE: reset is asynchronous on assertion; restart is the synchronous twin with the same values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level    <= LV_ONE;
            speed    <= SPD_RST;
            lo       <= '0;
            hi       <= STEP_V;
            cnt      <= '0;
            state    <= STEADY;
            level_up <= 1'b0;
            at_max   <= (NUM_LEVELS == 1);
        end else if (bus.restart) begin
            level    <= LV_ONE;
            speed    <= SPD_RST;
            lo       <= '0;
            hi       <= STEP_V;
            cnt      <= '0;
            state    <= STEADY;
            level_up <= 1'b0;
            at_max   <= (NUM_LEVELS == 1);
        end else begin
            level    <= level_d;
            speed    <= speed_d;
            cnt      <= cnt_d;
            state    <= state_d;
            level_up <= go_up;
            at_max   <= (level_d == LV_MAX);
            if (go_up) begin
                lo <= lo + STEP_V;
                hi <= hi + STEP_V;
            end else if (go_down) begin
                lo <= lo - STEP_V;
                hi <= hi - STEP_V;
            end
        end
    end

    tick_timer #(.LOAD_VALUE(BANNER_TICKS), .W(BAN_W)) u_banner (
        .clock (clock),
        .reset (reset),
        .clear (bus.restart),
        .load  (go_up),
        .tick  (bus.frame_tick),
        .count (unused_banner_count),
        .busy  (bus.banner)
    );

    assign bus.level    = level;
    assign bus.speed    = speed;
    assign bus.level_up = level_up;
    assign bus.at_max   = at_max;
endmodule

// File: doc/level_controller.md
LEVEL_CONTROLLER -- requirements
Module: level_controller

Interface
REQ-001 SHALL have parameter SCORE_W, default 12, width of the score input.
REQ-002 SHALL have parameter LEVEL_W, default 3, width of level and speed outputs.
REQ-003 SHALL have parameter NUM_LEVELS, default 6, highest level (levels run 1..NUM_LEVELS).
REQ-004 SHALL have parameter STEP, default 7, score points per level.
REQ-005 SHALL have parameter SPEED_BASE, default 2, speed at level 1.
REQ-006 SHALL have parameter RAMP_TICKS, default 4, frame ticks between unit speed increments.
REQ-007 SHALL have parameter BANNER_TICKS, default 60, frame ticks the banner stays asserted.
REQ-008 SHALL have port clock, input, 1, sole clock.
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port restart, input, 1, synchronous game restart, same effect as reset.
REQ-011 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-012 SHALL have port score, input, SCORE_W, current game score.
REQ-013 SHALL have ports level and speed, output, LEVEL_W each, registered.
REQ-014 SHALL have port level_up, output, 1, one-cycle pulse per level increment.
REQ-015 SHALL have port banner, output, 1, high while the level-up banner is shown.
REQ-016 SHALL have port at_max, output, 1, high when level == NUM_LEVELS.

Function
REQ-017 Level thresholds SHALL be lo = (level-1)*STEP and hi = level*STEP, held in SCORE_W+1-bit registers and updated incrementally by +/-STEP (no multiplier or divider).
REQ-018 When score >= hi and level < NUM_LEVELS, level SHALL increment by exactly 1 on the next edge, with level_up high for that one cycle.
REQ-019 A multi-level score jump SHALL climb one level per clock, producing one level_up pulse per step.
REQ-020 When score < lo and level > 1, level SHALL decrement by 1 per clock; no level_up pulse.
REQ-021 At level NUM_LEVELS, the hi comparison SHALL be ignored; level saturates and at_max = 1.
REQ-022 Target speed SHALL be SPEED_BASE + level - 1, saturating at 2^LEVEL_W - 1.
REQ-023 Ramp FSM SHALL have states STEADY (speed == target) and RAMP (speed < target), with a tick counter.
REQ-024 STEADY->RAMP SHALL occur when target > speed; the counter clears on entry.
REQ-025 In RAMP, each frame_tick SHALL increment the counter; at RAMP_TICKS it SHALL increment speed by 1 and clear; RAMP->STEADY when speed reaches target.
REQ-026 When target < speed, speed SHALL snap to target on the next edge, and the FSM goes to STEADY.
REQ-027 A level change coinciding with frame_tick SHALL count that tick toward the ramp.
REQ-028 On each level_up, banner SHALL assert and its counter SHALL reload to BANNER_TICKS; banner drops after BANNER_TICKS frame ticks without a new level_up.
REQ-029 restart SHALL take priority over all other inputs in the same cycle.

Reset
REQ-030 On reset or restart: level = 1, speed = SPEED_BASE, lo = 0, hi = STEP, FSM = STEADY, all counters = 0, level_up = 0, banner = 0, at_max = (NUM_LEVELS == 1).
REQ-031 Reset SHALL act asynchronously on assertion; restart SHALL act at the next edge, including mid-ramp or mid-banner.

Structure
REQ-032 Ramp FSM state encoding and default parameter constants SHALL live in shared package game_pkg.
REQ-033 The banner timer SHALL be a sub-module, tick_timer (load, tick, count, busy), reusable elsewhere in the game.

Verification
REQ-034 Score 0->6->7 -> level 1 then 2 one edge after 7; one level_up pulse; speed 2->3 after 4 frame ticks.
REQ-035 Score 0->40 in one cycle -> level 2,3,4,5,6 on five consecutive edges; five level_up pulses; at_max = 1; speed ramps 2->7 over 20 frame ticks.
REQ-036 Level 4, speed 5, score drops to 3 -> level steps down to 1 over 3 edges; speed snaps to 2; no level_up pulse.
REQ-037 restart asserted mid-ramp (speed 4, target 7) -> next edge: level 1, speed 2, banner 0, FSM STEADY.
REQ-038 Second level_up 30 ticks after the first -> banner stays high until 60 ticks after the second.
REQ-039 reset asserted between clock edges -> outputs take reset values before the next edge.
